// File: rtl/accum_adder_seg_mux_if.sv
// Bus between the board controls and the adder/display block: operands,
// strobes, registered arithmetic results and the multiplexed display pins.
interface accum_adder_seg_mux_if #(
   parameter int WIDTH = 8
);
   localparam int DIGITS = WIDTH / 4;

   logic [WIDTH-1:0]  A;
   logic [WIDTH-1:0]  B;
   logic              mode;
   logic              go;
   logic              clr;
   logic [WIDTH-1:0]  result;
   logic              Couts;
   logic              ovf;
   logic              done;
   logic [DIGITS-1:0] an;
   logic [6:0]        Display1;

   // Board/controller side: drives operands and strobes, watches the display.
   modport master (
      output A, B, mode, go, clr,
      input  result, Couts, ovf, done, an, Display1
   );

   // Adder/display block side.
   modport slave (
      input  A, B, mode, go, clr,
      output result, Couts, ovf, done, an, Display1
   );
endinterface

// File: rtl/accum_adder_seg_mux.sv
// Load/accumulate adder with registered result, carry and sticky overflow,
// shown in hex on a time-multiplexed bank of WIDTH/4 seven-segment digits.
module accum_adder_seg_mux #(
   parameter int WIDTH       = 8,
   parameter int REFRESH_DIV = 100000
) (
   input logic                  clk,
   input logic                  rst,
   accum_adder_seg_mux_if.slave bus
);
   localparam int DIGITS = WIDTH / 4;
   localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   // Active-low hex decode, bit0 = segment a ... bit6 = segment g.
   function automatic logic [6:0] f_hex7seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'b1000000;
         4'h1:    seg = 7'b1111001;
         4'h2:    seg = 7'b0100100;
         4'h3:    seg = 7'b0110000;
         4'h4:    seg = 7'b0011001;
         4'h5:    seg = 7'b0010010;
         4'h6:    seg = 7'b0000010;
         4'h7:    seg = 7'b1111000;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0010000;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b0000011;
         4'hC:    seg = 7'b1000110;
         4'hD:    seg = 7'b0100001;
         4'hE:    seg = 7'b0000110;
         default: seg = 7'b0001110;
      endcase
      return seg;
   endfunction

   logic [WIDTH-1:0]  r_result;
   logic              r_cout;
   logic              r_ovf;
   logic              r_done;
   logic [CNT_W-1:0]  r_cnt;
   logic [IDX_W-1:0]  r_idx;

   logic [WIDTH-1:0]  w_opa;
   logic [WIDTH:0]    w_sum;
   logic              w_cnt_wrap;
   logic [3:0]        w_nib;

   // Accumulate mode feeds the current result back in place of A's partner B.
   always_comb begin
      w_opa = bus.mode ? r_result : bus.B;
      w_sum = {1'b0, w_opa} + {1'b0, bus.A};
   end

   // Arithmetic state: reset beats clr, clr beats go; done marks each accepted go.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_result <= '0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
         r_done   <= 1'b0;
      end else if (bus.clr) begin
         r_result <= '0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
         r_done   <= 1'b0;
      end else if (bus.go) begin
         r_result <= w_sum[WIDTH-1:0];
         r_cout   <= w_sum[WIDTH];
         r_ovf    <= r_ovf | w_sum[WIDTH];
         r_done   <= 1'b1;
      end else begin
         r_done   <= 1'b0;
      end
   end

   assign w_cnt_wrap = (r_cnt == CNT_W'(REFRESH_DIV - 1));

   // Refresh timer and digit index; free-running, only rst restarts the scan.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (w_cnt_wrap) begin
         r_cnt <= '0;
         r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Pick the nibble belonging to the currently lit digit (digit 0 = LS nibble).
   always_comb begin
      w_nib = 4'h0;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_idx == IDX_W'(i)) w_nib = r_result[4*i +: 4];
      end
   end

   assign bus.result   = r_result;
   assign bus.Couts    = r_cout;
   assign bus.ovf      = r_ovf;
   assign bus.done     = r_done;
   assign bus.an       = ~(DIGITS'(1) << r_idx);
   assign bus.Display1 = f_hex7seg(w_nib);
endmodule

// File: tb/tb_accum_adder_seg_mux.sv
// Bench for accum_adder_seg_mux: directed literal checks plus randomized
// traffic compared every cycle against an arithmetic reference model.
module tb_accum_adder_seg_mux;
   localparam int W  = 8;
   localparam int RD = 4;
   localparam int ND = W / 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   accum_adder_seg_mux_if #(.WIDTH(W)) bus ();

   accum_adder_seg_mux #(.WIDTH(W), .REFRESH_DIV(RD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [6:0] seg_tab [16];
   initial begin
      seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
      seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
      seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
      seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
      seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
      seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
      seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
      seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain integer arithmetic and a cycle count since reset.
   int m_result = 0;
   bit m_cout = 0, m_ovf = 0, m_done = 0, m_known = 0;
   int m_tick = 0;

   always @(posedge clk) begin
      int s;
      if (rst) begin
         m_result = 0; m_cout = 0; m_ovf = 0; m_done = 0; m_tick = 0; m_known = 1;
      end else begin
         m_tick = m_tick + 1;
         if (bus.clr) begin
            m_result = 0; m_cout = 0; m_ovf = 0; m_done = 0;
         end else if (bus.go) begin
            s = (bus.mode ? m_result : int'(bus.B)) + int'(bus.A);
            m_cout   = (s >= (1 << W));
            m_result = s % (1 << W);
            m_ovf    = m_ovf | m_cout;
            m_done   = 1;
         end else begin
            m_done = 0;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      int dig;
      int nib;
      if (m_known) begin
         dig = (m_tick / RD) % ND;
         nib = (m_result >> (4 * dig)) & 15;
         chk("m_result", 32'(bus.result), 32'(m_result));
         chk("m_cout",   32'(bus.Couts),  32'(m_cout));
         chk("m_ovf",    32'(bus.ovf),    32'(m_ovf));
         chk("m_done",   32'(bus.done),   32'(m_done));
         chk("m_an",     32'(bus.an),     32'((~(1 << dig)) & ((1 << ND) - 1)));
         chk("m_seg",    32'(bus.Display1), 32'(seg_tab[nib]));
         chk("an_onehot", 32'($countones(~bus.an)), 32'd1);
      end
   end

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic md, input logic g, input logic c);
      @(negedge clk);
      bus.A = a; bus.B = b; bus.mode = md; bus.go = g; bus.clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_digit(input int d, input logic [6:0] exp_seg, input string name);
      logic [ND-1:0] want;
      int k;
      want = ND'(~(1 << d));
      k = 0;
      while (bus.an !== want && k < 4 * RD * ND) begin
         @(posedge clk); #1; k++;
      end
      if (bus.an !== want) chk({name, "_timeout"}, 32'(bus.an), 32'(want));
      else chk(name, 32'(bus.Display1), 32'(exp_seg));
   endtask

   initial begin
      bus.A = '0; bus.B = '0; bus.mode = 1'b0; bus.go = 1'b0; bus.clr = 1'b0;

      // Reset for two cycles, with go asserted to show reset priority.
      @(negedge clk); rst = 1'b1; bus.go = 1'b1; bus.A = 8'h55; bus.B = 8'h11;
      @(negedge clk);
      @(posedge clk); #1;
      chk("rst_result", 32'(bus.result), 32'h0);
      chk("rst_done",   32'(bus.done),   32'h0);
      chk("rst_an",     32'(bus.an),     32'b10);
      chk("rst_seg",    32'(bus.Display1), 32'b1000000);
      @(negedge clk); rst = 1'b0; bus.go = 1'b0;

      // Load 3C+05.
      drive(8'h3C, 8'h05, 1'b0, 1'b1, 1'b0);
      chk("load_result", 32'(bus.result), 32'h41);
      chk("load_cout",   32'(bus.Couts),  32'h0);
      chk("load_done",   32'(bus.done),   32'h1);
      drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("load_done_drop", 32'(bus.done), 32'h0);
      wait_digit(0, 7'b1111001, "load_dig0");
      wait_digit(1, 7'b0011001, "load_dig1");

      // Carry, then a carry-free load keeps ovf sticky.
      drive(8'hFF, 8'h02, 1'b0, 1'b1, 1'b0);
      chk("carry_result", 32'(bus.result), 32'h01);
      chk("carry_cout",   32'(bus.Couts),  32'h1);
      chk("carry_ovf",    32'(bus.ovf),    32'h1);
      drive(8'h01, 8'h01, 1'b0, 1'b1, 1'b0);
      chk("sticky_cout",  32'(bus.Couts),  32'h0);
      chk("sticky_ovf",   32'(bus.ovf),    32'h1);

      // Clear, then accumulate 80 twice with go held.
      drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("clr_ovf", 32'(bus.ovf), 32'h0);
      drive(8'h80, 8'h00, 1'b1, 1'b1, 1'b0);
      chk("acc1_result", 32'(bus.result), 32'h80);
      chk("acc1_cout",   32'(bus.Couts),  32'h0);
      chk("acc1_done",   32'(bus.done),   32'h1);
      drive(8'h80, 8'h00, 1'b1, 1'b1, 1'b0);
      chk("acc2_result", 32'(bus.result), 32'h00);
      chk("acc2_cout",   32'(bus.Couts),  32'h1);
      chk("acc2_ovf",    32'(bus.ovf),    32'h1);
      chk("acc2_done",   32'(bus.done),   32'h1);

      // clr beats a simultaneous go.
      drive(8'h12, 8'h34, 1'b0, 1'b1, 1'b0);
      drive(8'h12, 8'h34, 1'b0, 1'b1, 1'b1);
      chk("clrgo_result", 32'(bus.result), 32'h0);
      chk("clrgo_done",   32'(bus.done),   32'h0);

      // Reset with go high, then check the scan period and wrap.
      @(negedge clk); rst = 1'b1; bus.go = 1'b1; bus.A = 8'h77; bus.B = 8'h01;
      @(posedge clk); #1;
      chk("rstgo_result", 32'(bus.result), 32'h0);
      chk("rstgo_done",   32'(bus.done),   32'h0);
      chk("scan_0",       32'(bus.an),     32'b10);
      @(negedge clk); rst = 1'b0; bus.go = 1'b0;
      for (int k = 1; k <= 2 * RD; k++) begin
         @(posedge clk); #1;
         chk($sformatf("scan_%0d", k), 32'(bus.an), ((k / RD) % 2 == 0) ? 32'b10 : 32'b01);
      end

      // AF shows F on digit 0 and A on digit 1.
      drive(8'hA0, 8'h0F, 1'b0, 1'b1, 1'b0);
      chk("af_result", 32'(bus.result), 32'hAF);
      drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      wait_digit(0, 7'b0001110, "af_dig0");
      wait_digit(1, 7'b0001000, "af_dig1");

      // Randomized traffic, model comparison every cycle.
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         rst      = ($urandom_range(0, 79) == 0);
         bus.A    = W'($urandom);
         bus.B    = W'($urandom);
         bus.mode = 1'($urandom);
         bus.go   = ($urandom_range(0, 2) != 0);
         bus.clr  = ($urandom_range(0, 15) == 0);
      end
      @(negedge clk);
      rst = 1'b0; bus.go = 1'b0; bus.clr = 1'b0;
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/accum_adder_seg_mux.md
# accum_adder_seg_mux

Parametrised successor to the team's 4-bit adder + single seven-segment display path. It adds or accumulates WIDTH-bit operands on a strobe and registers the result, carry and sticky overflow. It then shows the result in hex on a time-multiplexed bank of WIDTH/4 seven-segment digits. The block sits between the board switches/buttons and the display pins.

## Interface
- WIDTH, 8: operand/result width; must be a multiple of 4, minimum 4.
- DIGITS, WIDTH/4: derived, not overridable; number of hex digits driven.
- REFRESH_DIV, 100000: clocks each digit stays lit; minimum 1.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B; ignored in accumulate mode.
- mode  in  1  0 = load (result <= A+B), 1 = accumulate (result <= result+A).
- go  in  1  operation strobe; sampled every clock while high.
- clr  in  1  clears result, cout and ovf.
- result  out  WIDTH  registered sum.
- Couts  out  1  carry-out of the most recent operation.
- ovf  out  1  sticky: set by any carry-out since last clr/rst.
- done  out  1  one-cycle pulse after each accepted go.
- an  out  DIGITS  digit enables, active-low, one-hot (exactly one bit low).
- Display1  out  7  segments, active-low, bit0 = a … bit6 = g.

## Operation
- Reset (rst=1 at an edge) sets the following, overriding all other inputs:
  - result=0, Couts=0, ovf=0, done=0.
  - Refresh counter 0, digit index 0, so an=~1 (digit 0 lit) and Display1=7'b1000000 ("0").
- clr=1 (rst=0): result=0, Couts=0, ovf=0, done=0. clr wins over a simultaneous go.
- go=1 (rst=0, clr=0) performs a (WIDTH+1)-bit add:
  - mode 0: {Couts,result} <= A+B.
  - mode 1: {Couts,result} <= result+A.
  - ovf <= ovf | carry.
  - done <= 1.
- go held high repeats the operation on every edge; done stays high for each. No edge detection is applied.
- go=0: result, Couts and ovf hold; done <= 0.
- Result wraps modulo 2^WIDTH; the carry is reported only through Couts and ovf.
- Digit scan:
  - The refresh counter counts 0..REFRESH_DIV-1. On the edge where it equals REFRESH_DIV-1 it returns to 0 and the digit index increments, wrapping DIGITS-1 -> 0.
  - Digit i shows result[4i+3:4i]; digit 0 is the least significant nibble.
  - an[i]=0 only for the current index.
- Scanning runs independently of go/clr; clr and go do not reset the scan.
- Hex decode (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110

## Timing
- Latency: result, Couts, ovf and done all update on the same edge that samples go. done is high for exactly the following cycle.
- an and Display1 are combinational from the registered digit index and result. A new result is visible on the lit digit in the cycle after the go edge.
- Each digit is lit for exactly REFRESH_DIV cycles; a full scan takes DIGITS*REFRESH_DIV cycles.
- Mid-operation reset: rst is sampled before go and clr. Outputs hold reset values from the next cycle onward.

## Test plan
- Load, WIDTH=8, REFRESH_DIV=4:
  - rst 2 cycles, then go=1 for one cycle with mode=0, A=8'h3C, B=8'h05 -> next cycle result=8'h41, Couts=0, done=1 for one cycle.
  - While digit 0 is lit, Display1=7'b1111001 ("1"); while digit 1 is lit, Display1=7'b0011001 ("4").
- Carry: mode=0, A=8'hFF, B=8'h02 -> result=8'h01, Couts=1, ovf=1.
  - A following load of 8'h01+8'h01 gives Couts=0 while ovf stays 1.
- Accumulate wrap: clr, then mode=1, A=8'h80, go held 2 cycles -> result 8'h80 then 8'h00, with Couts 0 then 1, ovf=1, and done high both cycles.
- Priority:
  - clr=1 and go=1 on the same edge -> result=0, done=0.
  - rst=1 with go=1 -> all outputs at reset values and an=2'b10.
- Scan, REFRESH_DIV=4:
  - an=2'b10 for 4 cycles, then 2'b01 for 4 cycles, then back to 2'b10 (wrap).
  - an never shows two bits low.
  - An operation with result=8'hAF shows "F"=0001110 on digit 0 and "A"=0001000 on digit 1.
